// File: rtl/serial_product_collector.sv
// -----------------------------------------------------------------------------
// serial_product_collector
//
// Purpose:
//   Reassembles the LSB-first serial product stream of a bit-serial 16x16
//   multiplier into a parallel WIDTH-bit word. It then presents that word
//   with a valid/ready handshake. A new stream may start on the same cycle
//   the previous word is accepted, which gives back-to-back operation.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse: product_bit carries product bit 0 this cycle
//   product_bit  in   serial product stream, LSB first, one bit per cycle
//   out_ready    in   consumer accepts product this cycle
//   out_valid    out  product holds a complete word (state HOLD)
//   product      out  assembled product word
//   busy         out  high while collecting (state COLLECT)
//   overrun      out  sticky: a start was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module serial_product_collector #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             product_bit,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             overrun
);

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Count value seen on the cycle the final (WIDTH-th) bit arrives.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t            state_reg,   state_next;
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;
  logic [WIDTH-1:0]  shift_reg,   shift_next;
  logic [WIDTH-1:0]  product_reg, product_next;
  logic              overrun_reg, overrun_next;

  // New bits enter at the MSB and move right. After WIDTH captures, the
  // first bit (product bit 0) has reached position 0.
  logic [WIDTH-1:0] shifted;
  assign shifted = {product_bit, shift_reg[WIDTH-1:1]};

  // A fresh collection starts from a cleared register. Earlier words
  // therefore never leak into the new one, even in back-to-back operation.
  logic [WIDTH-1:0] first_capture;
  assign first_capture = {product_bit, {(WIDTH-1){1'b0}}};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      product_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      product_reg <= product_next;
      overrun_reg <= overrun_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    product_next = product_reg;
    overrun_next = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = first_capture;
          cnt_next   = CNT_ONE;
          state_next = COLLECT;
        end
      end

      COLLECT: begin
        // The stream has no gaps, so a bit is taken on every cycle. A
        // start seen here belongs to a word that cannot be collected.
        shift_next = shifted;
        cnt_next   = cnt_reg + CNT_ONE;
        if (start) begin
          overrun_next = 1'b1;
        end
        if (cnt_reg == CNT_LAST) begin
          product_next = shifted;
          state_next   = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          if (start) begin
            // The handshake and the next bit 0 arrive together. Begin the
            // next word at once so that no bit is lost.
            shift_next = first_capture;
            cnt_next   = CNT_ONE;
            state_next = COLLECT;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else if (start) begin
          // No room for a new word while the held one is still pending.
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg == COLLECT);
  assign product   = product_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_product_collector.sv
// -----------------------------------------------------------------------------
// tb_serial_product_collector
//
// Purpose:
//   Directed self-checking bench for serial_product_collector. Each vector
//   streams a 32-bit word LSB first and checks it against the hand-computed
//   value. Every comparison goes through check().
// -----------------------------------------------------------------------------
module tb_serial_product_collector;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic             product_bit;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] product;
  logic             busy;
  logic             overrun;

  int err_count;
  int chk_count;

  serial_product_collector #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .product_bit (product_bit),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .product     (product),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Stream one full word LSB first. Start is raised on bit 0 and also on
  // bit restart_bit (use -1 for none). After every edge but the last, the
  // block must be collecting and must not show a valid word.
  task automatic stream(input logic [31:0] w, input int restart_bit, input string name);
    for (int i = 0; i < WIDTH; i++) begin
      start       = (i == 0) || (i == restart_bit);
      product_bit = w[i];
      step();
      if (i < WIDTH - 1) begin
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        check({name, " early_valid"}, {31'd0, out_valid}, 32'd0);
      end
    end
    start       = 1'b0;
    product_bit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    err_count   = 0;
    chk_count   = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    product_bit = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    #12;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst overrun", {31'd0, overrun}, 32'd0);
    check("rst product", product, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 0xFFFF*0xFFFF, consumer always ready: one-cycle valid WIDTH cycles on
    out_ready = 1'b1;
    stream(32'hFFFE0001, -1, "v1");
    $display("v1: product=%h out_valid=%0b overrun=%0b", product, out_valid, overrun);
    check("v1 valid", {31'd0, out_valid}, 32'd1);
    check("v1 product", product, 32'hFFFE0001);
    check("v1 overrun", {31'd0, overrun}, 32'd0);
    check("v1 busy_hold", {31'd0, busy}, 32'd0);
    step();
    check("v1 valid_drop", {31'd0, out_valid}, 32'd0);
    check("v1 product_keep", product, 32'hFFFE0001);

    // 3*5 with the consumer stalled for 10 cycles
    out_ready = 1'b0;
    stream(32'h0000000F, -1, "v2");
    for (int k = 0; k < 10; k++) begin
      check("v2 valid_held", {31'd0, out_valid}, 32'd1);
      check("v2 product_stable", product, 32'h0000000F);
      step();
    end
    check("v2 valid_11th", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("v2: product=%h out_valid=%0b after handshake", product, out_valid);
    check("v2 valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("v2 product_keep", product, 32'h0000000F);

    // Extra start at bit 10 of a collection: ignored, overrun set
    out_ready = 1'b1;
    stream(32'hA5A5A5A5, 10, "v3");
    $display("v3: product=%h overrun=%0b", product, overrun);
    check("v3 valid", {31'd0, out_valid}, 32'd1);
    check("v3 product", product, 32'hA5A5A5A5);
    check("v3 overrun", {31'd0, overrun}, 32'd1);
    step();
    check("v3 valid_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back: second start coincides with the first handshake
    stream(32'h12345678, -1, "v4a");
    check("v4a valid", {31'd0, out_valid}, 32'd1);
    check("v4a product", product, 32'h12345678);
    stream(32'h9ABCDEF0, -1, "v4b");
    $display("v4: product=%h out_valid=%0b", product, out_valid);
    check("v4b valid", {31'd0, out_valid}, 32'd1);
    check("v4b product", product, 32'h9ABCDEF0);
    step();
    check("v4b valid_drop", {31'd0, out_valid}, 32'd0);

    // Reset at bit 20 of a collection, then stream 0x00000001
    for (int i = 0; i < 20; i++) begin
      start       = (i == 0);
      product_bit = i[0];
      step();
    end
    start   = 1'b0;
    reset_n = 1'b0;
    #2;
    check("v5 rst busy", {31'd0, busy}, 32'd0);
    check("v5 rst valid", {31'd0, out_valid}, 32'd0);
    check("v5 rst overrun", {31'd0, overrun}, 32'd0);
    check("v5 rst product", product, 32'h0);
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 39) begin
        reset_n = 1'b1;
      end
    end
    check("v5 no_spurious_valid", {31'd0, out_valid}, 32'd0);
    stream(32'h00000001, -1, "v5");
    $display("v5: product=%h out_valid=%0b overrun=%0b", product, out_valid, overrun);
    check("v5 valid", {31'd0, out_valid}, 32'd1);
    check("v5 product", product, 32'h00000001);
    check("v5 overrun", {31'd0, overrun}, 32'd0);
    step();
    check("v5 valid_drop", {31'd0, out_valid}, 32'd0);

    // Start in HOLD without out_ready: ignored, overrun set, word kept
    out_ready = 1'b0;
    stream(32'h0F0F1234, -1, "v6");
    check("v6 valid", {31'd0, out_valid}, 32'd1);
    check("v6 overrun_before", {31'd0, overrun}, 32'd0);
    start       = 1'b1;
    product_bit = 1'b1;
    step();
    start       = 1'b0;
    product_bit = 1'b0;
    $display("v6: product=%h out_valid=%0b overrun=%0b busy=%0b", product, out_valid, overrun, busy);
    check("v6 valid_kept", {31'd0, out_valid}, 32'd1);
    check("v6 product_kept", product, 32'h0F0F1234);
    check("v6 overrun", {31'd0, overrun}, 32'd1);
    check("v6 busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    step();
    check("v6 valid_drop", {31'd0, out_valid}, 32'd0);
    check("v6 overrun_sticky", {31'd0, overrun}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule

// File: doc/serial_product_collector.md
SERIAL_PRODUCT_COLLECTOR -- requirements
Module: serial_product_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the product width in bits; it SHALL be twice the 16-bit multiplier operand width.
REQ-002 The block SHALL have port clock, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a pulse marking that product_bit carries product bit 0 in this cycle.
REQ-005 The block SHALL have port product_bit, input, 1 bit, the serial product stream from the bit-serial multiplier, LSB first, one bit per cycle.
REQ-006 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts product this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit, meaning product holds a complete word.
REQ-008 The block SHALL have port product, output, WIDTH bits, the assembled product.
REQ-009 The block SHALL have port busy, output, 1 bit, high while in COLLECT.
REQ-010 The block SHALL have port overrun, output, 1 bit, a sticky flag set when a start is dropped.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, COLLECT, HOLD.
REQ-012 In IDLE with start=1, the block SHALL capture product_bit as bit 0, set the bit counter to 1 and move to COLLECT.
REQ-013 In IDLE with start=0, the block SHALL capture nothing and leave the state unchanged.
REQ-014 In COLLECT, the block SHALL capture product_bit every cycle, with no gaps, and increment the counter by one.
REQ-015 Capture SHALL shift right with the new bit entering the MSB, so that after WIDTH captures the shift register holds the word LSB-aligned.
REQ-016 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during an operation.
REQ-017 On the cycle the WIDTH-th bit is captured, the block SHALL load product from the shifted value and move to HOLD.
- Consequence: out_valid rises exactly WIDTH cycles after the start cycle (start at cycle T gives out_valid high from cycle T+WIDTH).
REQ-018 In HOLD, out_valid SHALL be 1 and product SHALL be stable until out_valid and out_ready are both high.
REQ-019 On that handshake cycle, the block SHALL return to IDLE, and out_valid SHALL be 0 in the following cycle unless REQ-021 applies.
REQ-020 Outside HOLD, out_valid SHALL be 0, and product SHALL retain its last accepted value.
REQ-021 When start=1 in HOLD in the same cycle as the handshake, the block SHALL accept start, capture product_bit as bit 0, set the counter to 1 and go to COLLECT, giving back-to-back operation with no lost bit.
REQ-022 When start=1 in HOLD without out_ready, the block SHALL ignore start and set overrun, and product SHALL remain unchanged.
REQ-023 When start=1 in COLLECT, the block SHALL ignore it, continue the current collection unaffected and set overrun.
REQ-024 overrun SHALL remain set until reset; no other event clears it.
REQ-025 busy SHALL be 1 exactly when the state is COLLECT.
REQ-026 The block SHALL perform no arithmetic on the data; product SHALL be a bit-exact reassembly of the stream.

Reset
REQ-027 When reset_n is low, the block SHALL immediately, independent of clock, set state=IDLE, counter=0, shift register=0, product=0, out_valid=0, busy=0 and overrun=0.
REQ-028 Reset asserted mid-COLLECT or mid-HOLD SHALL abandon the partial or held word, and no out_valid SHALL follow.
REQ-029 After reset_n deasserts, the first rising edge SHALL observe the block in IDLE, and a start on that edge SHALL be accepted.

Verification
REQ-030 Stream the product of 0xFFFF*0xFFFF (0xFFFE0001) LSB first with start on bit 0 and out_ready=1 -> out_valid high for one cycle, WIDTH cycles after start, with product=0xFFFE0001 and overrun=0.
REQ-031 Stream 3*5 (0x0000000F) with out_ready=0 for 10 cycles, then 1 -> out_valid held 11 cycles, product=0x0000000F and stable throughout, and a single handshake.
REQ-032 Issue start again at bit 10 of a collection of 0xA5A5A5A5 -> product=0xA5A5A5A5, overrun=1 and busy unbroken.
REQ-033 Send two words 0x12345678 then 0x9ABCDEF0 with the second start coincident with the handshake of the first -> both words delivered intact with no idle cycle between streams.
REQ-034 Assert reset_n low at bit 20 of a collection, then release and stream 0x00000001 -> no spurious out_valid, then product=0x00000001, and all flags 0 after reset.
REQ-035 Assert start in HOLD with out_ready=0 -> start ignored, overrun=1 and the held product unchanged.
